// File: rtl/nibble_serial_seq_if.sv
// Request/result handshake between a controller and the nibble sequencer.
// The controller uses the master modport and the sequencer uses the slave modport.
interface nibble_serial_seq_if #(
   parameter int unsigned NIBBLES = 4
);
   logic                   start;
   logic [1:0]             op;
   logic [4*NIBBLES-1:0]   operand;
   logic                   busy;
   logic                   done;
   logic [4*NIBBLES-1:0]   result;
   logic                   carry_out;

   modport master (
      output start, op, operand,
      input  busy, done, result, carry_out
   );

   modport slave (
      input  start, op, operand,
      output busy, done, result, carry_out
   );
endinterface

// File: rtl/nibble_serial_seq.sv
// Drives a shared 4-bit invert/increment datapath one nibble per clock, LSB first,
// and chains each nibble's carry into the next to build wide PASS/INC/NOT/NEG.
module nibble_serial_seq #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   nibble_serial_seq_if.slave bus,
   output logic       en1,
   output logic       en2,
   output logic [3:0] di,
   input  logic [3:0] dout,
   input  logic       co
);
   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state;
   logic [1:0]        opreg;
   logic [W-1:0]      sreg;
   logic              carry;
   logic [IdxW-1:0]   idx;
   logic [W+3:0]      result_cat;

   // New nibble enters at the top; after NIBBLES shifts the LSB nibble sits at the bottom.
   assign result_cat = {dout, bus.result};

   // Datapath controls come from registered state only; zero outside RUN.
   assign en1 = bus.busy & opreg[1];
   assign en2 = bus.busy & carry;
   assign di  = bus.busy ? sreg[3:0] : 4'h0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= StIdle;
         opreg         <= 2'b00;
         sreg          <= '0;
         carry         <= 1'b0;
         idx           <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.result    <= '0;
         bus.carry_out <= 1'b0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  opreg         <= bus.op;
                  sreg          <= bus.operand;
                  carry         <= bus.op[0];  // INC and NEG start with carry-in 1
                  idx           <= '0;
                  bus.result    <= '0;
                  bus.carry_out <= 1'b0;
                  bus.busy      <= 1'b1;
                  state         <= StRun;
               end else begin
                  bus.busy <= 1'b0;
                  state    <= StIdle;
               end
            end
            StRun: begin
               bus.result <= result_cat[W+3:4];
               sreg       <= sreg >> 4;
               carry      <= co;
               idx        <= idx + IdxW'(1);
               if (idx == IdxW'(NIBBLES - 1)) begin
                  bus.carry_out <= co;
                  bus.busy      <= 1'b0;
                  bus.done      <= 1'b1;
                  state         <= StDone;
               end
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= StIdle;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_seq.sv
// Directed bench for nibble_serial_seq with NIBBLES=4 and a behavioural 4-bit datapath.
module tb_nibble_serial_seq;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en1, en2, co;
   logic [3:0] di, dout;
   int         checks = 0;
   int         fails  = 0;

   nibble_serial_seq_if #(.NIBBLES(4)) bus ();

   nibble_serial_seq #(.NIBBLES(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus),
      .en1  (en1),
      .en2  (en2),
      .di   (di),
      .dout (dout),
      .co   (co)
   );

   // External datapath: DO = (DI ^ {4{EN1}}) + EN2 with carry out
   assign {co, dout} = {1'b0, di ^ {4{en1}}} + {4'b0000, en2};

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge, then drop START
   task automatic accept(input logic [1:0] op, input logic [15:0] operand);
      bus.start   = 1'b1;
      bus.op      = op;
      bus.operand = operand;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 2'b00; bus.operand = 16'h0;
      tick(); tick();
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.result !== 16'h0) begin fails++; $display("FAIL reset_result: got %h want 0000", bus.result); end
      checks++; if ({bus.carry_out, en1, en2, di} !== 7'h0) begin fails++;
         $display("FAIL reset_dp: got co=%b en1=%b en2=%b di=%h want all 0", bus.carry_out, en1, en2, di); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_inc();
      accept(2'b01, 16'h00FF);
      checks++; if ({bus.busy, en1, en2, di} !== 7'b1_0_1_1111) begin fails++;
         $display("FAIL inc_first_run: got busy=%b en1=%b en2=%b di=%h want 1 0 1 f", bus.busy, en1, en2, di); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL inc_early_done: cycle %0d got 1 want 0", i); end
         tick();
      end
      checks++; if ({bus.done, bus.busy} !== 2'b10) begin fails++;
         $display("FAIL inc_done: got done=%b busy=%b want 1 0", bus.done, bus.busy); end
      checks++; if ({bus.carry_out, bus.result} !== {1'b0, 16'h0100}) begin fails++;
         $display("FAIL inc_result: got %b/%h want 0/0100", bus.carry_out, bus.result); end
      tick();
      checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL inc_done_pulse: got %b want 0", bus.done); end
   endtask

   task automatic test_inc_wrap();
      accept(2'b01, 16'hFFFF);
      for (int i = 0; i < 4; i++) begin
         checks++; if (en2 !== 1'b1) begin fails++; $display("FAIL wrap_chain: cycle %0d got en2=%b want 1", i, en2); end
         tick();
      end
      checks++; if ({bus.done, bus.carry_out, bus.result} !== {2'b11, 16'h0000}) begin fails++;
         $display("FAIL wrap_result: got done=%b co=%b res=%h want 1 1 0000", bus.done, bus.carry_out, bus.result); end
      tick();
   endtask

   task automatic test_neg();
      accept(2'b11, 16'h0001);
      repeat (4) tick();
      checks++; if ({bus.done, bus.carry_out, bus.result} !== {2'b10, 16'hFFFF}) begin fails++;
         $display("FAIL neg_one: got done=%b co=%b res=%h want 1 0 ffff", bus.done, bus.carry_out, bus.result); end
      tick();
      accept(2'b11, 16'h0000);
      checks++; if ({en1, en2} !== 2'b11) begin fails++; $display("FAIL neg_ctrl: got en1=%b en2=%b want 1 1", en1, en2); end
      repeat (4) tick();
      checks++; if ({bus.done, bus.carry_out, bus.result} !== {2'b11, 16'h0000}) begin fails++;
         $display("FAIL neg_zero: got done=%b co=%b res=%h want 1 1 0000", bus.done, bus.carry_out, bus.result); end
      tick();
   endtask

   task automatic test_back_to_back();
      accept(2'b10, 16'hA5C3);
      repeat (4) tick();
      checks++; if ({bus.done, bus.carry_out, bus.result} !== {2'b10, 16'h5A3C}) begin fails++;
         $display("FAIL b2b_not: got done=%b co=%b res=%h want 1 0 5a3c", bus.done, bus.carry_out, bus.result); end
      accept(2'b00, 16'hA5C3);
      checks++; if ({bus.busy, bus.result} !== {1'b1, 16'h0000}) begin fails++;
         $display("FAIL b2b_no_gap: got busy=%b res=%h want 1 0000", bus.busy, bus.result); end
      repeat (4) tick();
      checks++; if ({bus.done, bus.carry_out, bus.result} !== {2'b10, 16'hA5C3}) begin fails++;
         $display("FAIL b2b_pass: got done=%b co=%b res=%h want 1 0 a5c3", bus.done, bus.carry_out, bus.result); end
      tick();
   endtask

   task automatic test_start_busy();
      int dones = 0;
      accept(2'b01, 16'h00FF);
      bus.start = 1'b1; bus.op = 2'b11; bus.operand = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.done) dones++;
      end
      bus.start = 1'b0;
      tick();
      if (bus.done) dones++;
      checks++; if ({bus.done, bus.carry_out, bus.result} !== {2'b10, 16'h0100}) begin fails++;
         $display("FAIL busy_ignore: got done=%b co=%b res=%h want 1 0 0100", bus.done, bus.carry_out, bus.result); end
      repeat (4) begin
         tick();
         if (bus.done) dones++;
      end
      checks++; if (dones !== 1) begin fails++; $display("FAIL busy_one_done: got %0d want 1", dones); end
   endtask

   task automatic test_reset_mid_run();
      int dones = 0;
      accept(2'b10, 16'h1234);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if ({bus.busy, bus.done, bus.result} !== {2'b00, 16'h0000}) begin fails++;
         $display("FAIL midrst_state: got busy=%b done=%b res=%h want 0 0 0000", bus.busy, bus.done, bus.result); end
      checks++; if ({en1, en2, di} !== 6'h0) begin fails++;
         $display("FAIL midrst_dp: got en1=%b en2=%b di=%h want 0 0 0", en1, en2, di); end
      repeat (6) begin
         tick();
         if (bus.done || bus.busy) dones++;
      end
      checks++; if (dones !== 0) begin fails++; $display("FAIL midrst_idle: got %0d active cycles want 0", dones); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_inc();
      test_inc_wrap();
      test_neg();
      test_back_to_back();
      test_start_busy();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
